rr_arbiter4: RTL

Four-requester round-robin arbiter that shares one resource slot, such as the rotating one-hot output stage, between independent requesters. It issues a registered one-hot grant with rotating priority, so every active requester is served within bounded time. An optional hold limit pre-empts an owner that keeps its request high too long. It sits between the requesting sequencers and the shared resource's select lines.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter4.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and widths for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Priority pointer advance; 2-bit arithmetic wraps 3 -> 0.
    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        return idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;

    always_comb begin
        // Rotate so that requester ptr lands at bit 0.
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end
        any    = |req;
        idx    = any ? ptr + off : '0;
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant.
// Define ARB_HOLD_LIMIT_EN to pre-empt an owner after MAX_HOLD consecutive cycles.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] pick_req, pick_onehot;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             take;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              preempt_q, preempt_d;
`endif

    // The owner is masked so a released request cannot win the same edge.
    assign pick_req = req & ~grant_q;

    rr_pick u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q     <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                take = pick_any;
            end
            ARB_GRANT: begin
                if (req[owner_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
                    // At the limit: rotate if anyone else waits, otherwise saturate.
                    if (cnt_q == HoldLast) begin
                        take      = pick_any;
                        preempt_d = pick_any;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
`endif
                end else if (pick_any) begin
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    owner_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (take) begin
            state_d = ARB_GRANT;
            grant_d = pick_onehot;
            owner_d = pick_idx;
            ptr_d   = ptr_after(pick_idx);
`ifdef ARB_HOLD_LIMIT_EN
            cnt_d   = '0;
`endif
        end
    end

    always_comb begin
        grant     = grant_q;
        gnt_id    = owner_q;
        gnt_valid = (state_q == ARB_GRANT);
`ifdef ARB_HOLD_LIMIT_EN
        preempt   = preempt_q;
`else
        preempt   = 1'b0;
`endif
    end

endmodule
